// File: rtl/axi_lite_wr_arbiter_pkg.sv
// Shared types for the AXI4-Lite write arbiter.
package axi_lite_pkg;

  localparam int unsigned RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2,
    DONE      = 2'd3
  } wr_arb_state_t;

endpackage

// File: rtl/axi_lite_wr_arbiter_if.sv
// AXI4-Lite write channels (AW, W, B) between the arbiter and the fabric.
interface axi_lite_wr_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import axi_lite_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_wr_arbiter_rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// Shares one AXI4-Lite write channel set among NUM_REQ requesters, one
// complete write at a time, round-robin, with a one-cycle ack per write.
module axi_lite_wr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]  req_strb,
  output logic [NUM_REQ-1:0]             ack,
  output logic [RESP_W-1:0]              ack_resp,
  output logic                           busy,
  axi_lite_wr_arbiter_if.master          m_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [STRB_W-1:0] strb_arr [NUM_REQ];

  wr_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  resp_t              ack_resp_q, ack_resp_d;
  logic               busy_q, busy_d;

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               aw_done, w_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign strb_arr[g] = req_strb[g*STRB_W +: STRB_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A channel is finished once its valid is low or its handshake fires now.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  // Next-state and registered-output logic for the write sequencer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    ack_d      = '0;
    ack_resp_d = ack_resp_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant_d   = grant_idx;
          awaddr_d  = addr_arr[grant_idx];
          wdata_d   = data_arr[grant_idx];
          wstrb_d   = strb_arr[grant_idx];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        if (m_axi.awready) awvalid_d = 1'b0;
        if (m_axi.wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (m_axi.bvalid && bready_q) begin
          ack_resp_d = resp_t'(m_axi.bresp);
          bready_d   = 1'b0;
          ack_d      = NUM_REQ'(1) << grant_q;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      ack_q      <= '0;
      ack_resp_q <= OKAY;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      ack_q      <= ack_d;
      ack_resp_q <= ack_resp_d;
      busy_q     <= busy_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign ack           = ack_q;
  assign ack_resp      = ack_resp_q;
  assign busy          = busy_q;

endmodule
